// File: rtl/conv_ram_arbiter.sv
// Arbiter sharing the single-port conv SRAM wrapper between the image loader (port 0)
// and the convolution engine (port 1): round-robin per access, optional locked bursts.
module conv_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [1:0]            lock_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ram_write_en,
    output logic                  ram_read_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_ry
);

    localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam bit          LOCK_EN   = (MAX_BURST > 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 last_gnt_q, last_gnt_d;
    logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 burst_done;
    logic [1:0]           gnt;
    logic [1:0]           rvalid_q;

    assign cnt_inc    = burst_cnt_q + CNT_WIDTH'(1);
    assign burst_done = (cnt_inc >= CNT_WIDTH'(MAX_BURST));

    // State, ownership history and burst length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
            rvalid_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid_q    <= gnt & ~we_i;
        end
    end

    // Grant selection and next-state; a busy SRAM freezes everything
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = 2'b00;
        if (rst_n && ram_ry) begin
            unique case (state_q)
                IDLE: begin
                    if (req_i == 2'b11) begin
                        gnt = last_gnt_q ? 2'b01 : 2'b10;
                    end else begin
                        gnt = req_i;
                    end
                    if (LOCK_EN && gnt[0] && lock_i[0]) begin
                        state_d     = OWN0;
                        burst_cnt_d = CNT_WIDTH'(1);
                    end else if (LOCK_EN && gnt[1] && lock_i[1]) begin
                        state_d     = OWN1;
                        burst_cnt_d = CNT_WIDTH'(1);
                    end
                end
                OWN0: begin
                    gnt = {1'b0, req_i[0]};
                    if (req_i[0]) begin
                        if (!lock_i[0] || burst_done) begin
                            state_d     = IDLE;
                            burst_cnt_d = '0;
                        end else begin
                            burst_cnt_d = cnt_inc;
                        end
                    end else if (!lock_i[0]) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end
                end
                OWN1: begin
                    gnt = {req_i[1], 1'b0};
                    if (req_i[1]) begin
                        if (!lock_i[1] || burst_done) begin
                            state_d     = IDLE;
                            burst_cnt_d = '0;
                        end else begin
                            burst_cnt_d = cnt_inc;
                        end
                    end else if (!lock_i[1]) begin
                        state_d     = IDLE;
                        burst_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            endcase
            if (gnt[0]) begin
                last_gnt_d = 1'b0;
            end else if (gnt[1]) begin
                last_gnt_d = 1'b1;
            end
        end
    end

    // SRAM drive: grant is one-hot, so the two enables are mutually exclusive
    always_comb begin
        ram_write_en = |(gnt & we_i);
        ram_read_en  = |(gnt & ~we_i);
        ram_addr     = '0;
        ram_data_in  = '0;
        if (gnt[1]) begin
            ram_addr    = addr1_i;
            ram_data_in = wdata1_i;
        end else if (gnt[0]) begin
            ram_addr    = addr0_i;
            ram_data_in = wdata0_i;
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    // SRAM Q is already registered inside the wrapper; pass it through when qualified
    assign rdata_o  = (|rvalid_q) ? ram_data_out : '0;

endmodule
